// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and lock-loss counter constants for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        DAC_RST   = 3'd2,
        SETTLE    = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5
    } state_t;

    localparam int LLC_W = 8;
    localparam logic [LLC_W-1:0] LLC_MAX = '1;

    function automatic logic [LLC_W-1:0] sat_inc(input logic [LLC_W-1:0] v);
        return (v == LLC_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rst_sync2.sv
// rst_sync2: two-flop synchronizer with asynchronous clear; tie d high for reset release, or feed a level for data
module rst_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    // Clear at once on rst_n, then shift d through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: orders DAC reset pulse, settle wait and staggered domain release; reruns on lock loss or soft request
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOM       = 3,
    parameter int DAC_RST_CYC = 100,
    parameter int SETTLE_CYC  = 1000,
    parameter int STEP_CYC    = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             dac_rst_n,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             seq_done,
    output logic [LLC_W-1:0] lock_loss_cnt
);

    localparam int IW = $clog2(N_DOM + 1);

    logic             rst_s;
    logic             lock_s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic             dac_nx;
    logic [N_DOM-1:0] dom_nx;
    logic             done_nx;
    logic [LLC_W-1:0] llc_nx;
    logic             lost;

    rst_sync2 u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_s)
    );

    rst_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Lock only matters once a sequence has started
    assign lost = !lock_s && (state == DAC_RST || state == SETTLE || state == RELEASE || state == RUN);

    // Next state, timer, release index and registered output values
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        idx_nx   = idx;
        dac_nx   = dac_rst_n;
        dom_nx   = dom_rst_n;
        done_nx  = seq_done;
        llc_nx   = lock_loss_cnt;
        case (state)
            IDLE: begin
                dac_nx  = 1'b0;
                dom_nx  = '0;
                done_nx = 1'b0;
                if (rst_s) begin
                    state_nx = WAIT_LOCK;
                    timer_nx = '0;
                end
            end
            WAIT_LOCK: begin
                dac_nx  = 1'b0;
                dom_nx  = '0;
                done_nx = 1'b0;
                if (lock_s) begin
                    state_nx = DAC_RST;
                    timer_nx = '0;
                end
            end
            DAC_RST: begin
                timer_nx = timer + 1'b1;
                if (timer == CNT_W'(DAC_RST_CYC - 1)) begin
                    state_nx = SETTLE;
                    timer_nx = '0;
                    dac_nx   = 1'b1;
                end
            end
            SETTLE: begin
                timer_nx = timer + 1'b1;
                if (timer == CNT_W'(SETTLE_CYC - 1)) begin
                    state_nx = RELEASE;
                    timer_nx = '0;
                    idx_nx   = '0;
                end
            end
            RELEASE: begin
                timer_nx = timer + 1'b1;
                if (idx == IW'(N_DOM)) begin
                    state_nx = RUN;
                    done_nx  = 1'b1;
                end else if (timer == CNT_W'(STEP_CYC - 1)) begin
                    dom_nx   = dom_rst_n | (N_DOM'(1) << idx);
                    idx_nx   = idx + 1'b1;
                    timer_nx = '0;
                end
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_nx = DAC_RST;
                    timer_nx = '0;
                    dac_nx   = 1'b0;
                    dom_nx   = '0;
                    done_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                dac_nx   = 1'b0;
                dom_nx   = '0;
                done_nx  = 1'b0;
            end
        endcase
        if (lost) begin
            state_nx = WAIT_LOCK;
            timer_nx = '0;
            dac_nx   = 1'b0;
            dom_nx   = '0;
            done_nx  = 1'b0;
            llc_nx   = sat_inc(lock_loss_cnt);
        end
        if (!rst_s) state_nx = IDLE;
    end

    // All state and outputs clear asynchronously on rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            idx           <= '0;
            dac_rst_n     <= 1'b0;
            dom_rst_n     <= '0;
            seq_done      <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            idx           <= idx_nx;
            dac_rst_n     <= dac_nx;
            dom_rst_n     <= dom_nx;
            seq_done      <= done_nx;
            lock_loss_cnt <= llc_nx;
        end
    end

endmodule
